memory_bank: RTL and testbench

//  Parametrised single-port synchronous RAM. Successor to the fixed 8x256 CPU memory.

---
 rtl/memory_bank_pkg.sv | 17 +
 rtl/memory_bank_clear.sv | 54 +++++
 rtl/memory_bank.sv | 130 +++++++++++++
 tb/tb_memory_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bank_pkg.sv
// rtl/memory_bank_pkg.sv - shared encodings and helpers for memory_bank (MEMORY_BANK_PARITY_EN aware)
package memory_bank_pkg;

    typedef enum logic {
        MB_IDLE  = 1'b0,
        MB_CLEAR = 1'b1
    } mb_state_e;

    localparam logic MB_OP_READ  = 1'b0;
    localparam logic MB_OP_WRITE = 1'b1;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/memory_bank_clear.sv
// rtl/memory_bank_clear.sv - clear sweep counter and FSM for memory_bank
module memory_bank_clear
    import memory_bank_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic [ADDR_W-1:0] ptr,
    output logic              clr_we,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    mb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MB_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // A clear pulse restarts the sweep from word 0 regardless of state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (clear) begin
            state_d = MB_CLEAR;
            ptr_d   = '0;
        end else if (state_q == MB_CLEAR) begin
            if (ptr_q == LAST_PTR) begin
                state_d = MB_IDLE;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy   = (state_q == MB_CLEAR);
        clr_we = (state_q == MB_CLEAR);
        ptr    = ptr_q;
    end

endmodule

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - single-port RAM with request handshake and clear sweep; optional MEMORY_BANK_PARITY_EN
module memory_bank
    import memory_bank_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              operation,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] input_value,
    input  logic              clear,
    output logic              busy,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic              addr_err
`ifdef MEMORY_BANK_PARITY_EN
   ,output logic              parity_err
`endif
);

`ifdef MEMORY_BANK_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_we;
    logic              accept;
    logic              in_range;
    logic              rd_op;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  wr_data;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;

    logic [DATA_W-1:0] value_q, value_d;
    logic              value_valid_q, value_valid_d;
    logic              addr_err_q, addr_err_d;

    memory_bank_clear #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .ptr    (clr_ptr),
        .clr_we (clr_we),
        .busy   (busy)
    );

    // A same-cycle clear pulse wins over the request.
    assign req_ready = !busy && !clear;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
    assign rd_op     = accept && (operation == MB_OP_READ);

`ifdef MEMORY_BANK_PARITY_EN
    assign wr_word = {even_parity(64'(input_value)), input_value};
`else
    assign wr_word = input_value;
`endif

    // The sweep owns the write port while busy; requests are blocked then anyway.
    always_comb begin
        wr_en   = clr_we || (accept && (operation == MB_OP_WRITE) && in_range);
        wr_addr = clr_we ? clr_ptr : address;
        wr_data = clr_we ? '0 : wr_word;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem[address];

    always_comb begin
        value_d       = value_q;
        value_valid_d = rd_op;
        addr_err_d    = accept && !in_range;
        if (rd_op) begin
            value_d = in_range ? rd_word[DATA_W-1:0] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q       <= '0;
            value_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign addr_err    = addr_err_q;

`ifdef MEMORY_BANK_PARITY_EN
    logic parity_err_q, parity_err_d;

    // A stored word with odd total ones means the parity bit no longer matches.
    assign parity_err_d = rd_op && in_range && (^rd_word);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_memory_bank.sv
// tb/tb_memory_bank.sv - directed self-checking bench for memory_bank (MEMORY_BANK_PARITY_EN aware)
module tb_memory_bank;

    logic       clk;
    logic       reset;

    logic       req_valid, req_ready, operation, clear, busy, value_valid, addr_err;
    logic [7:0] address, input_value, value;

    logic       b_req_valid, b_req_ready, b_operation, b_clear, b_busy, b_value_valid, b_addr_err;
    logic [7:0] b_address, b_input_value, b_value;

`ifdef MEMORY_BANK_PARITY_EN
    logic       parity_err, b_parity_err;
`endif

    int checks = 0;
    int errors = 0;

    memory_bank #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .operation   (operation),
        .address     (address),
        .input_value (input_value),
        .clear       (clear),
        .busy        (busy),
        .value       (value),
        .value_valid (value_valid),
        .addr_err    (addr_err)
`ifdef MEMORY_BANK_PARITY_EN
       ,.parity_err  (parity_err)
`endif
    );

    memory_bank #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (b_req_valid),
        .req_ready   (b_req_ready),
        .operation   (b_operation),
        .address     (b_address),
        .input_value (b_input_value),
        .clear       (b_clear),
        .busy        (b_busy),
        .value       (b_value),
        .value_valid (b_value_valid),
        .addr_err    (b_addr_err)
`ifdef MEMORY_BANK_PARITY_EN
       ,.parity_err  (b_parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        req_valid = 1'b1; operation = 1'b0; address = a;
        check({tag, "_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        check({tag, "_valid"}, value_valid, 1);
        check({tag, "_value"}, value, exp);
        check({tag, "_aerr"}, addr_err, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1; operation = 1'b1; address = a; input_value = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic b_rd(input logic [7:0] a, input logic [7:0] exp, input logic aerr, input string tag);
        b_req_valid = 1'b1; b_operation = 1'b0; b_address = a;
        step();
        b_req_valid = 1'b0;
        check({tag, "_valid"}, b_value_valid, 1);
        check({tag, "_value"}, b_value, exp);
        check({tag, "_aerr"}, b_addr_err, aerr);
    endtask

    task automatic b_wr(input logic [7:0] a, input logic [7:0] d);
        b_req_valid = 1'b1; b_operation = 1'b1; b_address = a; b_input_value = d;
        step();
        b_req_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        req_valid = 0; operation = 0; address = 0; input_value = 0; clear = 0;
        b_req_valid = 0; b_operation = 0; b_address = 0; b_input_value = 0; b_clear = 0;
        repeat (2) step();

        check("rst_busy", busy, 1);
        check("rst_ready", req_ready, 0);
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_aerr", addr_err, 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        count_busy(n);
        check("sweep_len", n, 256);
        check("idle_ready", req_ready, 1);
        check("b_idle", b_busy, 0);

        // Reads after the sweep see zeros
        rd(8'd0, 8'h00, "t1_r0");
        rd(8'd9, 8'h00, "t1_r9");
        rd(8'd255, 8'h00, "t1_r255");

        // Write then immediate read of the same word
        wr(8'd9, 8'h0C);
        check("t2_wr_novalid", value_valid, 0);
        rd(8'd9, 8'h0C, "t2_r9");
        wr(8'd9, 8'h07);
        check("t2_hold_value", value, 8'h0C);
        check("t2_hold_novalid", value_valid, 0);
        step();
        check("t2_hold_value2", value, 8'h0C);

        // Interleaved writes and reads, single valid pulse per read
        rd(8'd9, 8'h07, "t3_r07");
        step();
        check("t3_pulse_once", value_valid, 0);
        wr(8'd9, 8'h08);
        rd(8'd9, 8'h08, "t3_r08");
        step();
        check("t3_pulse_once2", value_valid, 0);

        // Out-of-range on the DEPTH=200 instance
        b_wr(8'd5, 8'h55);
        b_wr(8'd250, 8'hAA);
        check("t4_wr_aerr", b_addr_err, 1);
        check("t4_wr_novalid", b_value_valid, 0);
        step();
        check("t4_aerr_drop", b_addr_err, 0);
        b_rd(8'd5, 8'h55, 0, "t4_r5");
        b_rd(8'd250, 8'h00, 1, "t4_r250");
        step();
        check("t4_aerr_once", b_addr_err, 0);
        b_rd(8'd0, 8'h00, 0, "t4_r0");
        b_rd(8'd199, 8'h00, 0, "t4_r199");
        b_rd(8'd250 - 8'd200, 8'h00, 0, "t4_r50");

        // Clear pulse beats a same-cycle request; restart mid-sweep
        wr(8'd100, 8'h5A);
        wr(8'd0, 8'hA5);
        req_valid = 1'b1; operation = 1'b1; address = 8'd50; input_value = 8'h33;
        clear = 1'b1;
        #1;
        check("t5_ready_clr", req_ready, 0);
        step();
        clear = 1'b0; req_valid = 1'b0;
        check("t5_busy", busy, 1);
        repeat (100) step();
        req_valid = 1'b1; operation = 1'b1; address = 8'd200; input_value = 8'h77;
        clear = 1'b1;
        step();
        clear = 1'b0; req_valid = 1'b0;
        count_busy(n);
        check("t5_restart_len", n, 256);
        rd(8'd0, 8'h00, "t5_r0");
        rd(8'd50, 8'h00, "t5_r50");
        rd(8'd100, 8'h00, "t5_r100");
        rd(8'd200, 8'h00, "t5_r200");

`ifdef MEMORY_BANK_PARITY_EN
        wr(8'd3, 8'h15);
        rd(8'd3, 8'h15, "t6_r3_good");
        check("t6_perr_good", parity_err, 0);
        dut.mem[3] = dut.mem[3] ^ 9'h100;
        rd(8'd3, 8'h15, "t6_r3_bad");
        check("t6_perr_bad", parity_err, 1);
`endif

        // Reset during a read result drops the strobe and restarts the sweep
        wr(8'd7, 8'h42);
        req_valid = 1'b1; operation = 1'b0; address = 8'd7;
        step();
        req_valid = 1'b0;
        check("rr_valid", value_valid, 1);
        reset = 1'b0;
        #1;
        check("rr_valid_drop", value_valid, 0);
        check("rr_value_zero", value, 0);
        check("rr_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        count_busy(n);
        check("rr_sweep_len", n, 256);
        rd(8'd7, 8'h00, "rr_r7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
